// File: rtl/decode_issue_ctrl.sv
// Single-slot decode/issue stage: holds one fetched instruction, classifies
// its immediate format, presents it downstream with a valid/ready handshake
// and inserts one bubble when a load result is needed by the next instruction.
module decode_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [2:0]  id_imm_type,
    output logic        id_imm_used,
    output logic        id_illegal,
    output logic [15:0] stall_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_VALID = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [2:0]  r_imm_type;
    logic        r_imm_used;
    logic        r_illegal;
    logic [15:0] r_stall_count;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [2:0]  w_imm_type;
    logic        w_imm_used;
    logic        w_illegal;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_xfer;
    logic        w_accept;
    logic        w_dep_load;
    logic [4:0]  w_dep_rd;
    logic        w_hazard;

    assign w_opcode = if_instr[6:0];
    assign w_funct3 = if_instr[14:12];

    // Classify the incoming instruction: immediate format and register usage
    always_comb begin
        w_imm_type = 3'b111;
        w_imm_used = 1'b0;
        w_illegal  = 1'b0;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_OPIMM, OP_JALR: begin
                w_imm_type = 3'b000;
                w_imm_used = 1'b1;
            end
            OP_STORE: begin
                w_imm_type = 3'b001;
                w_imm_used = 1'b1;
                w_use_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                w_imm_type = 3'b010;
                w_imm_used = 1'b1;
                w_use_rs2  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm_type = 3'b011;
                w_imm_used = 1'b1;
                w_use_rs1  = 1'b0;
            end
            OP_JAL: begin
                w_imm_type = 3'b100;
                w_imm_used = 1'b1;
                w_use_rs1  = 1'b0;
            end
            OP_SYSTEM: begin
                if (w_funct3[2]) begin
                    w_imm_type = 3'b101;
                    w_imm_used = 1'b1;
                end
            end
            OP_OP: begin
                w_use_rs2 = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
                w_use_rs1 = 1'b0;
            end
        endcase
    end

    // id_valid follows the current state, so a transfer still completes in a flush cycle
    assign id_valid = !rst && (r_state == S_VALID);
    assign w_xfer   = id_valid && id_ready;
    assign if_ready = !rst && !flush && (r_state != S_HOLD) &&
                      ((r_state == S_EMPTY) || w_xfer);
    assign w_accept = if_valid && if_ready;

    // The departing instruction is the one currently held in the slot
    assign w_dep_rd   = r_instr[11:7];
    assign w_dep_load = (r_instr[6:0] == OP_LOAD) && (w_dep_rd != 5'd0);
    assign w_hazard   = w_accept && w_xfer && w_dep_load &&
                        ((w_use_rs1 && (w_dep_rd == if_instr[19:15])) ||
                         (w_use_rs2 && (w_dep_rd == if_instr[24:20])));

    // Slot state machine: flush beats accept and beats the one-cycle HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_VALID;
                S_VALID: begin
                    if (w_xfer && w_accept) r_state <= w_hazard ? S_HOLD : S_VALID;
                    else if (w_xfer)        r_state <= S_EMPTY;
                end
                S_HOLD:  r_state <= S_VALID;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Capture instruction, PC and decode fields on accept; otherwise hold them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= 32'd0;
            r_pc       <= 32'd0;
            r_imm_type <= 3'b000;
            r_imm_used <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_instr    <= if_instr;
            r_pc       <= if_pc;
            r_imm_type <= w_imm_type;
            r_imm_used <= w_imm_used;
            r_illegal  <= w_illegal;
        end
    end

    // Count load-use bubbles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (w_hazard && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign id_instr    = r_instr;
    assign id_pc       = r_pc;
    assign id_imm_type = r_imm_type;
    assign id_imm_used = r_imm_used;
    assign id_illegal  = r_illegal;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: streaming, load-use bubble,
// backpressure, decode table, flush during HOLD, reset and counter saturation.
module tb_decode_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_type;
    logic        id_imm_used;
    logic        id_illegal;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    decode_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_imm_type (id_imm_type),
        .id_imm_used (id_imm_used),
        .id_illegal  (id_illegal),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_LW    = 32'h00002103;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_LUI   = 32'h12345037;

    logic [31:0] dec_instr [4];
    logic [2:0]  dec_type  [4];
    logic        dec_used  [4];
    logic        dec_ill   [4];

    initial begin
        dec_instr[0] = I_LUI;        dec_type[0] = 3'b011; dec_used[0] = 1'b1; dec_ill[0] = 1'b0;
        dec_instr[1] = 32'h0000D073; dec_type[1] = 3'b101; dec_used[1] = 1'b1; dec_ill[1] = 1'b0;
        dec_instr[2] = 32'h00000033; dec_type[2] = 3'b111; dec_used[2] = 1'b0; dec_ill[2] = 1'b0;
        dec_instr[3] = 32'h0000007F; dec_type[3] = 3'b111; dec_used[3] = 1'b0; dec_ill[3] = 1'b1;

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        rst = 1'b0;

        // Streaming addi then sw
        id_ready = 1'b1;
        offer(I_ADDI, 32'h100);
        #1;
        chk("st_if_ready0", {31'd0, if_ready}, 32'd1);
        tick();
        chk("st_valid0", {31'd0, id_valid}, 32'd1);
        chk("st_instr0", id_instr, I_ADDI);
        chk("st_pc0", id_pc, 32'h100);
        chk("st_type0", {29'd0, id_imm_type}, 32'd0);
        chk("st_used0", {31'd0, id_imm_used}, 32'd1);
        offer(I_SW, 32'h104);
        #1;
        chk("st_if_ready1", {31'd0, if_ready}, 32'd1);
        tick();
        chk("st_valid1", {31'd0, id_valid}, 32'd1);
        chk("st_instr1", id_instr, I_SW);
        chk("st_type1", {29'd0, id_imm_type}, 32'd1);
        chk("st_used1", {31'd0, id_imm_used}, 32'd1);
        if_valid = 1'b0;
        tick();
        chk("st_drain", {31'd0, id_valid}, 32'd0);
        chk("st_stall", {16'd0, stall_count}, 32'd0);

        // Load-use: lw x2 then add x3,x1,x2
        offer(I_LW, 32'h200);
        tick();
        chk("lu_lw_valid", {31'd0, id_valid}, 32'd1);
        chk("lu_lw_instr", id_instr, I_LW);
        offer(I_ADD, 32'h204);
        #1;
        chk("lu_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, id_valid}, 32'd0);
        chk("lu_stall", {16'd0, stall_count}, 32'd1);
        chk("lu_hold_ready", {31'd0, if_ready}, 32'd0);
        if_valid = 1'b0;
        tick();
        chk("lu_add_valid", {31'd0, id_valid}, 32'd1);
        chk("lu_add_instr", id_instr, I_ADD);
        chk("lu_add_pc", id_pc, 32'h204);
        chk("lu_add_type", {29'd0, id_imm_type}, 32'd7);
        chk("lu_add_used", {31'd0, id_imm_used}, 32'd0);
        tick();

        // Backpressure on jal
        offer(I_JAL, 32'h300);
        tick();
        id_ready = 1'b0;
        offer(I_ADDI, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", {31'd0, id_valid}, 32'd1);
            chk("bp_type", {29'd0, id_imm_type}, 32'd4);
            chk("bp_instr", id_instr, I_JAL);
            chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
            tick();
        end
        id_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("bp_next_valid", {31'd0, id_valid}, 32'd1);
        chk("bp_next_instr", id_instr, I_ADDI);
        chk("bp_next_pc", id_pc, 32'h304);
        if_valid = 1'b0;
        tick();

        // Decode table, streamed back to back
        for (int i = 0; i < 4; i++) begin
            offer(dec_instr[i], 32'h1000 + 32'(i * 4));
            tick();
            chk("dec_valid", {31'd0, id_valid}, 32'd1);
            chk("dec_instr", id_instr, dec_instr[i]);
            chk("dec_type", {29'd0, id_imm_type}, {29'd0, dec_type[i]});
            chk("dec_used", {31'd0, id_imm_used}, {31'd0, dec_used[i]});
            chk("dec_illegal", {31'd0, id_illegal}, {31'd0, dec_ill[i]});
        end
        if_valid = 1'b0;
        tick();
        chk("dec_drain", {31'd0, id_valid}, 32'd0);

        // Flush during HOLD
        offer(I_LW, 32'h400);
        tick();
        offer(I_ADD, 32'h404);
        tick();
        chk("fl_hold_valid", {31'd0, id_valid}, 32'd0);
        chk("fl_hold_stall", {16'd0, stall_count}, 32'd2);
        if_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_empty", {31'd0, id_valid}, 32'd0);
        chk("fl_stall", {16'd0, stall_count}, 32'd2);
        chk("fl_instr_kept", id_instr, I_ADD);
        tick();
        chk("fl_never", {31'd0, id_valid}, 32'd0);

        // Reset while VALID
        offer(I_LUI, 32'h500);
        tick();
        chk("rv_valid", {31'd0, id_valid}, 32'd1);
        if_valid = 1'b0;
        id_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rv_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rv_rst_ready", {31'd0, if_ready}, 32'd0);
        tick();
        rst = 1'b0;
        id_ready = 1'b1;
        chk("rv_valid_after", {31'd0, id_valid}, 32'd0);
        chk("rv_instr", id_instr, 32'd0);
        chk("rv_pc", id_pc, 32'd0);
        chk("rv_type", {29'd0, id_imm_type}, 32'd0);
        chk("rv_used", {31'd0, id_imm_used}, 32'd0);
        chk("rv_illegal", {31'd0, id_illegal}, 32'd0);
        chk("rv_stall", {16'd0, stall_count}, 32'd0);

        // Saturation of the bubble counter
        force dut.r_stall_count = 16'hFFFF;
        #1;
        release dut.r_stall_count;
        #1;
        chk("sat_preset", {16'd0, stall_count}, 32'hFFFF);
        offer(I_LW, 32'h600);
        tick();
        offer(I_ADD, 32'h604);
        tick();
        chk("sat_hold", {31'd0, id_valid}, 32'd0);
        chk("sat_stall", {16'd0, stall_count}, 32'hFFFF);
        if_valid = 1'b0;
        tick();
        chk("sat_add_valid", {31'd0, id_valid}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 The ports SHALL be as follows; all outputs are registered except if_ready and id_valid:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discards the held instruction.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  decode accepts the instruction this cycle.
- if_instr  in  32  offered instruction word.
- if_pc  in  32  offered PC.
- id_valid  out  1  decoded instruction presented downstream.
- id_ready  in  1  downstream accepts.
- id_instr  out  32  held instruction word.
- id_pc  out  32  held PC.
- id_imm_type  out  3  immediate-generator select.
- id_imm_used  out  1  instruction consumes an immediate.
- id_illegal  out  1  opcode not recognised.
- stall_count  out  16  saturating count of load-use bubbles.

Function
REQ-003 The block SHALL hold a single instruction slot with states EMPTY, VALID and HOLD.
REQ-004 Output handshake: id_valid SHALL be 1 only in state VALID; a transfer occurs when id_valid && id_ready.
REQ-005 Input handshake: if_ready SHALL be 1 when rst=0, flush=0 and state is not HOLD, and either the state is EMPTY or a transfer occurs this cycle.
REQ-006 An accept occurs when if_valid && if_ready; on an accept the slot SHALL capture if_instr and if_pc, and the decode fields SHALL be computed from if_instr[6:0] and funct3.
REQ-007 id_imm_type encoding:
- 000 for LOAD 0000011, OP-IMM 0010011 and JALR 1100111.
- 001 for STORE 0100011.
- 010 for BRANCH 1100011.
- 011 for LUI 0110111 and AUIPC 0010111.
- 100 for JAL 1101111.
- 101 for SYSTEM 1110011 with funct3[2]=1.
REQ-008 The following SHALL give id_imm_type=111 and id_imm_used=0, with id_illegal=0:
- OP 0110011.
- SYSTEM with funct3[2]=0.
REQ-009 Any other opcode SHALL give id_imm_type=111, id_imm_used=0 and id_illegal=1, and the instruction SHALL still be presented downstream normally.
REQ-010 id_imm_used SHALL be 1 for every type 000-101.
REQ-011 rs1 use: every recognised opcode SHALL use rs1 except LUI, AUIPC, JAL and illegal opcodes.
REQ-012 rs2 use: OP, STORE and BRANCH SHALL use rs2.
REQ-013 Load-use detection: a hazard exists when all of the following hold in the same cycle:
- an accept coincides with a transfer;
- the departing instruction is LOAD with rd != 0;
- rd equals the incoming rs1 (when rs1 is used) or the incoming rs2 (when rs2 is used).
REQ-014 Transitions:
- EMPTY -> VALID on an accept.
- VALID -> VALID on a transfer plus an accept without hazard.
- VALID -> HOLD on a transfer plus an accept with hazard.
- VALID -> EMPTY on a transfer without an accept.
- HOLD -> VALID after exactly one cycle, regardless of id_ready.
- Otherwise the state is unchanged.
REQ-015 While in VALID or HOLD without a transfer, all id_* registers SHALL remain stable.
REQ-016 Latency: an instruction accepted in cycle N SHALL have id_valid=1 in cycle N+1, or in cycle N+2 on a hazard.
REQ-017 stall_count SHALL increment by 1 on each entry to HOLD and saturate at 16'hFFFF.
REQ-018 Flush: when flush=1, the next state SHALL be EMPTY and no accept SHALL occur (if_ready=0).
- Flush takes priority over accept and over HOLD.
- id_instr, id_pc and the decode fields keep their values.
- stall_count is unaffected.
REQ-019 A transfer occurring in the same cycle as a flush SHALL still complete downstream, because id_valid is combinational from the current state.

Reset
REQ-020 When rst=1 at a clock edge, the following SHALL reset:
- state to EMPTY.
- id_instr, id_pc and stall_count to 0.
- id_imm_type to 000.
- id_imm_used and id_illegal to 0.
REQ-021 While rst=1, if_ready and id_valid SHALL be 0; rst SHALL override flush and any in-progress HOLD.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Streaming: 0x00500093 (addi x1,x0,5) then 0x00112023 (sw) with id_ready=1 -> id_imm_type 000 then 001, id_imm_used=1, one instruction per cycle, stall_count=0.
- Load-use: 0x00002103 (lw x2) followed by 0x002081B3 (add x3,x1,x2) -> one id_valid=0 cycle, the add is presented in cycle N+2, stall_count=1.
- Backpressure: id_ready=0 for 3 cycles holding 0x000000EF (jal) -> id_valid=1, id_imm_type=100 stable, if_ready=0; release -> transfer and next accept in the same cycle.
- Decode: 0x12345037 (lui) gives type 011; 0x0000D073 (csrrwi) gives 101; 0x00000033 (add) gives 111 with used=0; 0x0000007F gives illegal=1 with type 111.
- Flush in HOLD: flush=1 during the HOLD cycle -> EMPTY next cycle, the held instruction is never presented, stall_count unchanged.
- Reset mid-VALID: rst=1 -> next cycle id_valid=0, all id_* outputs 0, stall_count=0; a forced stall_count of 0xFFFF SHALL saturate on a further hazard.
